// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection, branch flush and data-memory freeze control
// for the 5-stage pipeline; drives stage-register enables and flushes.
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ifid_rs,
    input  logic [3:0]  ifid_rt,
    input  logic [3:0]  ifid_rd,
    input  logic        ifid_uses_rs,
    input  logic        ifid_uses_rt,
    input  logic        ifid_is_store,
    input  logic [3:0]  idex_rf_waddr,
    input  logic        idex_rf_wen,
    input  logic        idex_mem2reg,
    input  logic        branch_taken_exmem,
    input  logic        dmem_busy,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic        pipe_freeze,
    output logic        stall_active,
    output logic [15:0] load_stall_count,
    output logic        mem_timeout_err
);

    // state   | meaning
    // RUN     | normal flow, load-use compare active
    // LDSTALL | remaining load-use stall cycles counted by scnt
    // MEMWAIT | pipeline frozen on dmem_busy; ret_state resumes afterwards
    typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

    state_t      state, state_n, ret_state, ret_state_n, eff_state;
    logic [3:0]  scnt, scnt_n;
    logic [15:0] busy_cnt;
    logic        hazard;
    logic        pc_wen_c, ifid_wen_c, ifid_flush_c, idex_bubble_c;
    logic        exmem_flush_c, pipe_freeze_c, stall_c;

    assign hazard = idex_mem2reg & idex_rf_wen & (idex_rf_waddr != 4'd0) &
                    ((ifid_uses_rs  & (idex_rf_waddr == ifid_rs)) |
                     (ifid_uses_rt  & (idex_rf_waddr == ifid_rt)) |
                     (ifid_is_store & (idex_rf_waddr == ifid_rd)));

    // Leaving MEMWAIT behaves exactly like the state that was frozen.
    assign eff_state = (state == MEMWAIT) ? ret_state : state;

    always_comb begin
        state_n       = state;
        ret_state_n   = ret_state;
        scnt_n        = scnt;
        pc_wen_c      = 1'b0;
        ifid_wen_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        exmem_flush_c = 1'b0;
        pipe_freeze_c = 1'b0;
        stall_c       = 1'b0;
        if (dmem_busy) begin
            pipe_freeze_c = 1'b1;
            state_n       = MEMWAIT;
            if (state != MEMWAIT)
                ret_state_n = state;
        end else if (branch_taken_exmem) begin
            pc_wen_c      = 1'b1;
            ifid_wen_c    = 1'b1;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            exmem_flush_c = 1'b1;
            state_n       = RUN;
            scnt_n        = 4'd0;
        end else if (eff_state == LDSTALL) begin
            idex_bubble_c = 1'b1;
            stall_c       = 1'b1;
            scnt_n        = scnt - 4'd1;
            state_n       = (scnt == 4'd1) ? RUN : LDSTALL;
        end else if (hazard) begin
            idex_bubble_c = 1'b1;
            stall_c       = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_n = LDSTALL;
                scnt_n  = 4'(LOAD_STALL_CYCLES - 1);
            end else begin
                state_n = RUN;
            end
        end else begin
            pc_wen_c   = 1'b1;
            ifid_wen_c = 1'b1;
            state_n    = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            scnt      <= 4'd0;
        end else begin
            state     <= state_n;
            ret_state <= ret_state_n;
            scnt      <= scnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt         <= 16'd0;
            mem_timeout_err  <= 1'b0;
            load_stall_count <= 16'd0;
        end else begin
            if (!dmem_busy)
                busy_cnt <= 16'd0;
            else if (busy_cnt != 16'(MEM_TIMEOUT))
                busy_cnt <= busy_cnt + 16'd1;
            if (dmem_busy && (busy_cnt >= 16'(MEM_TIMEOUT - 1)))
                mem_timeout_err <= 1'b1;
            if (stall_c && (load_stall_count != 16'hFFFF))
                load_stall_count <= load_stall_count + 16'd1;
        end
    end

    // Control outputs are held low for the whole reset pulse.
    assign pc_wen       = rst_n & pc_wen_c;
    assign ifid_wen     = rst_n & ifid_wen_c;
    assign ifid_flush   = rst_n & ifid_flush_c;
    assign idex_bubble  = rst_n & idex_bubble_c;
    assign exmem_flush  = rst_n & exmem_flush_c;
    assign pipe_freeze  = rst_n & pipe_freeze_c;
    assign stall_active = rst_n & stall_c;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with LOAD_STALL_CYCLES=2, MEM_TIMEOUT=4.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ifid_rs, ifid_rt, ifid_rd, idex_rf_waddr;
    logic        ifid_uses_rs, ifid_uses_rt, ifid_is_store;
    logic        idex_rf_wen, idex_mem2reg, branch_taken_exmem, dmem_busy;
    logic        pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_flush;
    logic        pipe_freeze, stall_active, mem_timeout_err;
    logic [15:0] load_stall_count;

    int errors = 0;
    int checks = 0;

    hazard_stall_unit #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
        .ifid_is_store(ifid_is_store),
        .idex_rf_waddr(idex_rf_waddr), .idex_rf_wen(idex_rf_wen),
        .idex_mem2reg(idex_mem2reg),
        .branch_taken_exmem(branch_taken_exmem), .dmem_busy(dmem_busy),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .pipe_freeze(pipe_freeze), .stall_active(stall_active),
        .load_stall_count(load_stall_count), .mem_timeout_err(mem_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifid_rs = 0; ifid_rt = 0; ifid_rd = 0;
        ifid_uses_rs = 0; ifid_uses_rt = 0; ifid_is_store = 0;
        idex_rf_waddr = 0; idex_rf_wen = 0; idex_mem2reg = 0;
        branch_taken_exmem = 0; dmem_busy = 0;
    endtask

    task automatic load_use_rs(input logic [3:0] r);
        idle();
        idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = r;
        ifid_uses_rs = 1; ifid_rs = r;
    endtask

    // Advance to the next falling edge and let combinational outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // {pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, stall_active}
    function automatic logic [6:0] ctl();
        return {pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, stall_active};
    endfunction

    localparam logic [6:0] C_RUN    = 7'b1100000;
    localparam logic [6:0] C_STALL  = 7'b0001001;
    localparam logic [6:0] C_FREEZE = 7'b0000010;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_ZERO   = 7'b0000000;

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("reset_ctl", 32'(ctl()), 32'(C_ZERO));
        chk("reset_cnt", 32'(load_stall_count), 0);
        chk("reset_err", 32'(mem_timeout_err), 0);
        @(negedge clk); rst_n = 1; #1;
        chk("run_idle", 32'(ctl()), 32'(C_RUN));

        // load r3 -> dependent rs=3: two stall cycles
        step(); load_use_rs(4'd3); #1;
        chk("lu_cyc1", 32'(ctl()), 32'(C_STALL));
        step();
        chk("lu_cyc2", 32'(ctl()), 32'(C_STALL));
        step(); idle(); #1;
        chk("lu_done", 32'(ctl()), 32'(C_RUN));
        chk("lu_cnt", 32'(load_stall_count), 2);

        // r0 never hazards
        step(); load_use_rs(4'd0); #1;
        chk("r0_ctl", 32'(ctl()), 32'(C_RUN));
        step();
        chk("r0_cnt", 32'(load_stall_count), 2);

        // rt matches but is not used
        idle(); idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd7; ifid_rt = 4'd7; #1;
        chk("rt_unused", 32'(ctl()), 32'(C_RUN));

        // store data dependency on rd
        step(); idle(); idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd5;
        ifid_is_store = 1; ifid_rd = 4'd5; #1;
        chk("st_cyc1", 32'(ctl()), 32'(C_STALL));
        step();
        chk("st_cyc2", 32'(ctl()), 32'(C_STALL));
        step(); idex_mem2reg = 0; #1;
        chk("st_noload", 32'(ctl()), 32'(C_RUN));
        chk("st_cnt", 32'(load_stall_count), 4);

        // freeze in the middle of a stall
        step(); load_use_rs(4'd3); #1;
        chk("fz_cyc1", 32'(ctl()), 32'(C_STALL));
        for (int i = 0; i < 3; i++) begin
            step(); dmem_busy = 1; #1;
            chk($sformatf("fz_busy%0d", i), 32'(ctl()), 32'(C_FREEZE));
        end
        step(); dmem_busy = 0; #1;
        chk("fz_resume", 32'(ctl()), 32'(C_STALL));
        step(); idle(); #1;
        chk("fz_done", 32'(ctl()), 32'(C_RUN));
        chk("fz_cnt", 32'(load_stall_count), 6);
        chk("fz_noerr", 32'(mem_timeout_err), 0);

        // branch aborts a stall in its first LDSTALL cycle
        step(); load_use_rs(4'd3); #1;
        chk("br_haz", 32'(ctl()), 32'(C_STALL));
        step(); branch_taken_exmem = 1; #1;
        chk("br_flush", 32'(ctl()), 32'(C_BRANCH));
        step(); idle(); #1;
        chk("br_run", 32'(ctl()), 32'(C_RUN));
        chk("br_cnt", 32'(load_stall_count), 7);

        // branch and hazard in the same RUN cycle
        step(); load_use_rs(4'd9); branch_taken_exmem = 1; #1;
        chk("brhz_ctl", 32'(ctl()), 32'(C_BRANCH));
        step(); idle(); #1;
        chk("brhz_run", 32'(ctl()), 32'(C_RUN));
        chk("brhz_cnt", 32'(load_stall_count), 7);

        // memory timeout after 4 consecutive busy cycles (visible after the 4th edge)
        for (int i = 1; i <= 6; i++) begin
            step(); dmem_busy = 1; #1;
            chk($sformatf("to_err%0d", i), 32'(mem_timeout_err), (i >= 5) ? 1 : 0);
            chk($sformatf("to_frz%0d", i), 32'(ctl()), 32'(C_FREEZE));
        end
        step(); dmem_busy = 0; #1;
        chk("to_sticky", 32'(mem_timeout_err), 1);
        chk("to_run", 32'(ctl()), 32'(C_RUN));

        // reset mid-stall clears everything and forces outputs low
        step(); load_use_rs(4'd3); #1;
        chk("rs_haz", 32'(ctl()), 32'(C_STALL));
        #1 rst_n = 0; #1;
        chk("rs_ctl", 32'(ctl()), 32'(C_ZERO));
        chk("rs_err", 32'(mem_timeout_err), 0);
        chk("rs_cnt", 32'(load_stall_count), 0);
        step(); idle(); rst_n = 1; #1;
        chk("rs_run", 32'(ctl()), 32'(C_RUN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard and stall controller for the 16-register, 5-stage core. It detects load-use hazards that operand forwarding cannot cover and holds PC/IF-ID while inserting ID/EX bubbles for a programmable number of cycles. It flushes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is busy. It sits beside the forwarding logic, driving the stage-register write enables and flushes.

## Interface
- LOAD_STALL_CYCLES, 2, total stall cycles per load-use hazard, detect cycle included; legal range 1..15
- MEM_TIMEOUT, 255, consecutive dmem_busy cycles before mem_timeout_err sets; legal range 1..65535
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_rs  in  4  source register A of the instruction in ID
- ifid_rt  in  4  source register B of the instruction in ID
- ifid_rd  in  4  rd field of the instruction in ID; read as store data
- ifid_uses_rs  in  1  ID instruction reads rs
- ifid_uses_rt  in  1  ID instruction reads rt
- ifid_is_store  in  1  ID instruction is a store and reads rd
- idex_rf_waddr  in  4  destination register of the instruction in EX
- idex_rf_wen  in  1  EX instruction writes the register file
- idex_mem2reg  in  1  EX instruction is a load
- branch_taken_exmem  in  1  taken branch resolved in MEM
- dmem_busy  in  1  data memory not ready
- pc_wen  out  1  PC update enable
- ifid_wen  out  1  IF/ID register write enable
- ifid_flush  out  1  zero IF/ID
- idex_bubble  out  1  load NOP controls into ID/EX
- exmem_flush  out  1  zero EX/MEM controls
- pipe_freeze  out  1  all stage registers hold
- stall_active  out  1  a load-use stall cycle is in progress
- load_stall_count  out  16  saturating count of load-use stall cycles
- mem_timeout_err  out  1  sticky memory-timeout flag

## Operation
- States: RUN, LDSTALL, MEMWAIT. The state, a 4-bit stall counter `scnt`, a return-state register, a 16-bit busy counter and the output counters are registered. All other outputs are combinational from state and inputs.
- hazard = idex_mem2reg & idex_rf_wen & (idex_rf_waddr != 0) & ((ifid_uses_rs & idex_rf_waddr==ifid_rs) | (ifid_uses_rt & idex_rf_waddr==ifid_rt) | (ifid_is_store & idex_rf_waddr==ifid_rd)).
- Register 0 never creates a hazard.
- Priority in every state: dmem_busy > branch_taken_exmem > hazard or LDSTALL.
- Freeze, when dmem_busy=1:
  - Outputs: pipe_freeze=1, pc_wen=0, ifid_wen=0, all other outputs 0.
  - Next state is MEMWAIT. Entered from RUN or LDSTALL, the current state is saved as the return state.
  - scnt holds.
- MEMWAIT with dmem_busy=0: outputs follow the return state's decode this cycle. Next state follows the return state's transition rules.
- Branch, when branch_taken_exmem=1 and not busy:
  - Outputs: pc_wen=1, ifid_wen=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - Next state is RUN. This aborts any LDSTALL and clears scnt to 0.
- RUN with hazard:
  - Outputs: pc_wen=0, ifid_wen=0, idex_bubble=1, stall_active=1.
  - If LOAD_STALL_CYCLES>1, go to LDSTALL with scnt=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- RUN with no event: pc_wen=1, ifid_wen=1, all other outputs 0.
- LDSTALL with no event:
  - Same outputs as the RUN-with-hazard case. The hazard compare is ignored.
  - scnt decrements. When scnt==1, the next state is RUN.
- load_stall_count increments on every cycle with stall_active=1 and saturates at 0xFFFF.
- Busy counter:
  - Counts consecutive dmem_busy cycles, saturating at MEM_TIMEOUT. It clears on any cycle with dmem_busy=0.
  - When it reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until reset.
  - The freeze continues regardless of the error.

## Timing
- Reset (rst_n=0, asynchronous):
  - Registered values: state=RUN, scnt=0, return state=RUN, busy counter=0, load_stall_count=0, mem_timeout_err=0.
  - While rst_n=0, every output is forced to 0, pc_wen included.
- First edge after release: normal RUN decode.
- Control outputs have zero latency: they respond in the same cycle as their inputs.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles of stall_active, excluding frozen cycles. The dependent instruction leaves ID on the following edge.
- Freeze cycles are inserted transparently: after busy drops, the remaining stall cycles still equal scnt.
- Reset asserted mid-stall: the stall is abandoned and the block returns to RUN immediately.
- A branch and a hazard in the same cycle resolve as a branch. No stall is counted.

## Test plan
- Load r3 in EX, ID uses_rs with rs=3, LOAD_STALL_CYCLES=2 -> pc_wen=0 and idex_bubble=1 for exactly 2 cycles, then pc_wen=1; load_stall_count=2.
- Load with waddr=0 matching rs=0 -> no stall; pc_wen stays 1; load_stall_count stays 0.
- Store in ID with rd=5 behind a load to r5 -> stall of 2 cycles; the same case with idex_mem2reg=0 -> no stall.
- dmem_busy held for 3 cycles in the middle of a 2-cycle stall -> pipe_freeze=1 for 3 cycles, then 1 remaining stall cycle; total stall_active cycles = 2.
- branch_taken_exmem in the first LDSTALL cycle -> ifid_flush, idex_bubble and exmem_flush all 1 that cycle; RUN the next cycle with pc_wen=1.
- MEM_TIMEOUT=4, dmem_busy held for 6 cycles -> mem_timeout_err rises on the 4th busy cycle and stays 1 after busy drops; rst_n pulse clears it and all outputs read 0 during reset.
